// File: rtl/buf_loader_pkg.sv
// Shared definitions for the motion-buffer host loader.
//   - host command opcodes and response byte codes
//   - parser state encoding
//   - instruction word geometry (5 bytes = 40 bits)
//   - ack_code(): builds the ACK byte for a command
package buf_loader_pkg;

  localparam logic [7:0] CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_START    = 8'h03;
  localparam logic [7:0] CMD_ABORT    = 8'h04;
  localparam logic [7:0] CMD_STATUS   = 8'h05;

  localparam logic [7:0] ACK_BASE   = 8'hA0;
  localparam logic [7:0] NAK        = 8'hEE;
  localparam logic [7:0] STATUS_HDR = 8'h5A;

  localparam int WORD_BYTES = 5;
  localparam int WORD_W     = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    S_CMD,
    S_ARG,
    S_CNT,
    S_DATA,
    S_RESP
  } state_t;

  function automatic logic [7:0] ack_code(input logic [7:0] cmd);
    return ACK_BASE | {4'h0, cmd[3:0]};
  endfunction

endpackage

// File: rtl/buf_loader_word_asm.sv
// Little-endian instruction word assembler.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : drop any partially collected word (index back to 0)
//   byte_valid  : byte_data is the next byte of the current word
//   last        : combinational, this byte completes the word
//   word        : assembled word (valid while done is high)
//   done        : one-cycle strobe, the cycle after the last byte
module buf_loader_word_asm
  import buf_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              last,
  output logic [WORD_W-1:0] word,
  output logic              done
);

  logic [2:0] idx;

  assign last = byte_valid && (idx == 3'(WORD_BYTES - 1));

  // Bytes shift in from the top, so after five bytes the first one sits
  // in bits [7:0] and the fifth in bits [39:32].
  // NOTE: reset is synchronous here to match the rest of the host-link logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (byte_valid) begin
        word <= {byte_data, word[WORD_W-1:8]};
        idx  <= last ? 3'd0 : idx + 3'd1;
        done <= last;
      end
    end
  end

endmodule

// File: rtl/buf_loader.sv
// Host-side front end for the motion buffer executor.
// Parses host command frames from an RX byte stream, writes 40-bit words
// into the executor program buffer, issues start/abort and returns
// ACK/NAK/status bytes on a TX byte stream.
//   rx_data/rx_valid   : host bytes, one-cycle strobe, no backpressure
//   tx_data/tx_valid/tx_ready : response bytes, held until accepted
//   buf_addr/buf_data/buf_wr  : program buffer write port
//   start/start_addr, abort   : executor control pulses
//   complete, exec_pc, exec_error : executor feedback
//   running            : executor started and not yet completed/aborted
module buf_loader
  import buf_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [WORD_W-1:0] buf_data,
  output logic              buf_wr,
  output logic              start,
  output logic [ADDR_W-1:0] start_addr,
  output logic              abort,
  input  logic              complete,
  input  logic [15:0]       exec_pc,
  input  logic [7:0]        exec_error,
  output logic              running
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_next;
  logic [7:0]        cmd;
  logic              arg_half;
  logic [7:0]        arg_lo;
  logic [15:0]       arg_value;
  logic [8:0]        word_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [1:0]        resp_idx;
  logic [15:0]       stat_pc;
  logic              stat_running, stat_overrun;
  logic              overrun;
  logic [ADDR_W-1:0] wr_ptr;

  logic in_frame, tmo_hit, tx_accept, status_more;
  logic asm_valid, asm_clear, asm_last, asm_done;
  logic set_addr_go, start_go, abort_go, status_go, resp_go;
  logic [7:0] resp_byte, status_byte;

  // The error code is not part of the current status response.
  logic unused_exec_error;
  assign unused_exec_error = ^exec_error;

  assign arg_value   = {rx_data, arg_lo};
  assign in_frame    = (state == S_ARG) || (state == S_CNT) || (state == S_DATA);
  assign tmo_hit     = in_frame && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tx_valid    = (state == S_RESP);
  assign tx_accept   = tx_valid && tx_ready;
  assign status_more = (cmd == CMD_STATUS) && (resp_idx != 2'd3);
  assign asm_valid   = (state == S_DATA) && rx_valid;
  assign asm_clear   = (state != S_DATA) || tmo_hit;
  assign buf_addr    = wr_ptr;
  assign buf_wr      = asm_done;

  buf_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .last       (asm_last),
    .word       (buf_data),
    .done       (asm_done)
  );

  // Status byte following the one currently presented.
  always_comb begin
    unique case (resp_idx)
      2'd0:    status_byte = stat_pc[7:0];
      2'd1:    status_byte = stat_pc[15:8];
      default: status_byte = {stat_overrun, stat_running, 6'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    set_addr_go = 1'b0;
    start_go    = 1'b0;
    abort_go    = 1'b0;
    status_go   = 1'b0;
    resp_go     = 1'b0;
    resp_byte   = NAK;
    unique case (state)
      S_CMD: if (rx_valid) begin
        case (rx_data)
          CMD_SET_ADDR, CMD_START: state_next = S_ARG;
          CMD_WRITE:               state_next = S_CNT;
          CMD_ABORT: begin
            abort_go   = 1'b1;
            resp_go    = 1'b1;
            resp_byte  = ack_code(rx_data);
            state_next = S_RESP;
          end
          CMD_STATUS: begin
            status_go  = 1'b1;
            resp_go    = 1'b1;
            resp_byte  = STATUS_HDR;
            state_next = S_RESP;
          end
          default: begin
            resp_go    = 1'b1;
            state_next = S_RESP;
          end
        endcase
      end
      S_ARG: begin
        if (tmo_hit) begin
          state_next = S_CMD;
        end else if (rx_valid && arg_half) begin
          resp_go    = 1'b1;
          state_next = S_RESP;
          if (cmd == CMD_SET_ADDR) begin
            set_addr_go = 1'b1;
            resp_byte   = ack_code(cmd);
          end else if (!running) begin
            start_go  = 1'b1;
            resp_byte = ack_code(cmd);
          end
        end
      end
      S_CNT: begin
        if (tmo_hit)       state_next = S_CMD;
        else if (rx_valid) state_next = S_DATA;
      end
      S_DATA: begin
        if (tmo_hit) begin
          state_next = S_CMD;
        end else if (asm_last && word_cnt == 9'd1) begin
          resp_go    = 1'b1;
          resp_byte  = ack_code(CMD_WRITE);
          state_next = S_RESP;
        end
      end
      S_RESP: if (tx_ready && !status_more) state_next = S_CMD;
      default: state_next = S_CMD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd          <= '0;
      arg_half     <= 1'b0;
      arg_lo       <= '0;
      word_cnt     <= '0;
      tmo_cnt      <= '0;
      resp_idx     <= '0;
      stat_pc      <= '0;
      stat_running <= 1'b0;
      stat_overrun <= 1'b0;
      overrun      <= 1'b0;
      wr_ptr       <= '0;
      tx_data      <= '0;
      start        <= 1'b0;
      start_addr   <= '0;
      abort        <= 1'b0;
      running      <= 1'b0;
    end else begin
      start <= start_go;
      abort <= abort_go;
      if (start_go) start_addr <= ADDR_W'(arg_value);

      // A start issued together with a completion leaves the executor running.
      if (start_go)                  running <= 1'b1;
      else if (abort_go || complete) running <= 1'b0;

      if (!in_frame || rx_valid) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;

      if (state == S_CMD && rx_valid) cmd <= rx_data;

      if (state == S_CMD) begin
        arg_half <= 1'b0;
      end else if (state == S_ARG && rx_valid) begin
        arg_half <= 1'b1;
        arg_lo   <= rx_data;
      end

      if (state == S_CNT && rx_valid) word_cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
      else if (asm_last)              word_cnt <= word_cnt - 9'd1;

      if (set_addr_go)   wr_ptr <= ADDR_W'(arg_value);
      else if (asm_done) wr_ptr <= wr_ptr + 1'b1;

      if (status_go) begin
        stat_pc      <= exec_pc;
        stat_running <= running;
        stat_overrun <= overrun;
        resp_idx     <= '0;
      end else if (tx_accept) begin
        resp_idx <= resp_idx + 2'd1;
      end

      if (resp_go)                       tx_data <= resp_byte;
      else if (tx_accept && status_more) tx_data <= status_byte;

      // Only an overrun that was actually reported is cleared; a byte dropped
      // while that report is stalled stays flagged for the next STATUS.
      if (state == S_RESP && rx_valid)
        overrun <= 1'b1;
      else if (tx_accept && cmd == CMD_STATUS && resp_idx == 2'd3 && stat_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buf_loader.sv
// Scoreboard bench for buf_loader: directed host frames push expected
// buffer writes, TX bytes and start addresses into queues; a monitor
// compares whatever the DUT presents against the queue heads.
module tb_buf_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] buf_addr;
  logic [39:0] buf_data;
  logic        buf_wr;
  logic        start;
  logic [15:0] start_addr;
  logic        abort;
  logic        complete;
  logic [15:0] exec_pc;
  logic [7:0]  exec_error;
  logic        running;

  always #5 clk = ~clk;

  buf_loader #(.TIMEOUT_CYCLES(TMO), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_wr(buf_wr),
    .start(start), .start_addr(start_addr), .abort(abort),
    .complete(complete), .exec_pc(exec_pc), .exec_error(exec_error),
    .running(running)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [39:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_start[$];
  int          exp_abort;
  int          n_vec;
  int          n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [39:0] w);
    for (int i = 0; i < 5; i++) send(w[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 500;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_start.size() != 0 ||
            exp_abort != 0) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0)
      check("drain_timeout", 64'(exp_tx.size() + exp_wr.size() + exp_start.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_data"},    64'(tx_data),    64'd0);
    check({tag, "_tx_valid"},   64'(tx_valid),   64'd0);
    check({tag, "_buf_addr"},   64'(buf_addr),   64'd0);
    check({tag, "_buf_data"},   64'(buf_data),   64'd0);
    check({tag, "_buf_wr"},     64'(buf_wr),     64'd0);
    check({tag, "_start"},      64'(start),      64'd0);
    check({tag, "_start_addr"}, 64'(start_addr), 64'd0);
    check({tag, "_abort"},      64'(abort),      64'd0);
    check({tag, "_running"},    64'(running),    64'd0);
  endtask

  task automatic monitor();
    wr_t e;
    logic [15:0] sa;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (buf_wr) begin
          if (exp_wr.size() == 0) check("buf_wr_unexpected", 64'(buf_wr), 64'd0);
          else begin
            e = exp_wr.pop_front();
            check("buf_addr", 64'(buf_addr), 64'(e.addr));
            check("buf_data", 64'(buf_data), 64'(e.data));
          end
        end
        if (tx_valid) begin
          if (exp_tx.size() == 0) check("tx_unexpected", 64'(tx_valid), 64'd0);
          else begin
            // Compared every cycle it is offered, so a stall proves stability.
            check("tx_data", 64'(tx_data), 64'(exp_tx[0]));
            if (tx_ready) void'(exp_tx.pop_front());
          end
        end
        if (start) begin
          if (exp_start.size() == 0) check("start_unexpected", 64'(start), 64'd0);
          else begin
            sa = exp_start.pop_front();
            check("start_addr", 64'(start_addr), 64'(sa));
          end
        end
        if (abort) begin
          if (exp_abort == 0) check("abort_unexpected", 64'(abort), 64'd0);
          else exp_abort--;
        end
      end
    end
  endtask

  task automatic run_tests();
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // SET_ADDR 0x0010 then two words.
    exp_tx.push_back(8'hA1);
    send(8'h01); send(8'h10); send(8'h00);
    wait_idle();
    exp_wr.push_back('{16'h0010, 40'h4305060708});
    exp_wr.push_back('{16'h0011, 40'h5544332211});
    exp_tx.push_back(8'hA2);
    send(8'h02); send(8'h02);
    send_word(40'h4305060708);
    send_word(40'h5544332211);
    wait_idle();

    // Address wrap 0xFFFF -> 0x0000.
    exp_tx.push_back(8'hA1);
    send(8'h01); send(8'hFF); send(8'hFF);
    wait_idle();
    exp_wr.push_back('{16'hFFFF, 40'h0102030405});
    exp_wr.push_back('{16'h0000, 40'hA1B2C3D4E5});
    exp_tx.push_back(8'hA2);
    send(8'h02); send(8'h02);
    send_word(40'h0102030405);
    send_word(40'hA1B2C3D4E5);
    wait_idle();

    // Unknown opcode.
    exp_tx.push_back(8'hEE);
    send(8'h09);
    wait_idle();

    // START accepted, repeated START refused, accepted again after complete.
    exp_start.push_back(16'h0010);
    exp_tx.push_back(8'hA3);
    send(8'h03); send(8'h10); send(8'h00);
    wait_idle();
    check("running_after_start", 64'(running), 64'd1);
    exp_tx.push_back(8'hEE);
    send(8'h03); send(8'h20); send(8'h00);
    wait_idle();
    check("running_after_nak", 64'(running), 64'd1);
    complete = 1'b1;
    tick();
    complete = 1'b0;
    tick();
    check("running_after_complete", 64'(running), 64'd0);
    exp_start.push_back(16'h0030);
    exp_tx.push_back(8'hA3);
    send(8'h03); send(8'h30); send(8'h00);
    wait_idle();

    // STATUS with a stalled TX and a dropped byte during the stall.
    tx_ready = 1'b0;
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h40);
    send(8'h05);
    repeat (5) tick();
    send(8'h77);
    repeat (14) tick();
    tx_ready = 1'b1;
    wait_idle();
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12); exp_tx.push_back(8'hC0);
    send(8'h05);
    wait_idle();
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h40);
    send(8'h05);
    wait_idle();

    // ABORT.
    exp_abort = 1;
    exp_tx.push_back(8'hA4);
    send(8'h04);
    wait_idle();
    check("running_after_abort", 64'(running), 64'd0);

    // Partial word then silence: no write, no response, parser recovers.
    send(8'h02); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC);
    repeat (TMO + 10) tick();
    exp_tx.push_back(8'hA1);
    send(8'h01); send(8'h00); send(8'h00);
    wait_idle();
    exp_wr.push_back('{16'h0000, 40'hDEADBEEF01});
    exp_tx.push_back(8'hA2);
    send(8'h02); send(8'h01);
    send_word(40'hDEADBEEF01);
    wait_idle();

    // Reset in the middle of a START argument while running.
    exp_start.push_back(16'h0050);
    exp_tx.push_back(8'hA3);
    send(8'h03); send(8'h50); send(8'h00);
    wait_idle();
    check("running_before_rst", 64'(running), 64'd1);
    send(8'h03); send(8'h60);
    rst = 1'b1;
    tick();
    check_all_zero("midframe_rst");
    rst = 1'b0;
    tick();
    check("start_after_rst", 64'(start), 64'd0);
    exp_tx.push_back(8'hA1);
    send(8'h01); send(8'h22); send(8'h00);
    wait_idle();

    check("leftover_tx",    64'(exp_tx.size()),    64'd0);
    check("leftover_wr",    64'(exp_wr.size()),    64'd0);
    check("leftover_start", 64'(exp_start.size()), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    tx_ready   = 1'b1;
    complete   = 1'b0;
    exec_pc    = 16'h1234;
    exec_error = 8'h00;
    exp_abort  = 0;
    n_vec      = 0;
    n_err      = 0;
    fork
      monitor();
      run_tests();
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
